// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs a single-outstanding request/response bus
// handshake, applies redirects, and presents one instruction to IF. Optional macro: FETCH_ADEL_CHECK_EN.
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'hBFC00000,
  parameter int unsigned EXC_ADEL_BIT = 0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [3:0]  stall_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_target_i,
  input  logic        exception_i,
  input  logic [31:0] exception_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_inst_ren_o,
  output logic        if_inst_valid_o,
  output logic [31:0] if_exception_type_o,
  output logic        fetch_stall_req_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  if (EXC_ADEL_BIT > 31) begin : g_adel_bit_range
    $error("EXC_ADEL_BIT must select a bit of the 32-bit exception vector");
  end

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_cancel;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_inst;
  logic        r_hold_ren;
`ifdef FETCH_ADEL_CHECK_EN
  localparam logic [31:0] ADEL_MASK = 32'd1 << EXC_ADEL_BIT;
  logic [31:0] r_hold_exc;
`endif

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_launch;
  logic [31:0] w_launch_addr;

  // A launch starts a fresh request; it covers every path that returns to S_REQ.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_redirect    = exception_i | branch_enable_i;
    w_target      = exception_i ? exception_pc_i : branch_target_i;
    w_launch      = 1'b0;
    w_launch_addr = r_pc;
    unique case (r_state)
      S_IDLE: begin
        w_launch      = 1'b1;
        w_launch_addr = w_redirect ? w_target : r_pc;
      end
      S_WAIT: begin
        if (inst_data_ok_i && (r_cancel || w_redirect)) begin
          w_launch      = 1'b1;
          w_launch_addr = w_redirect ? w_target : r_pc;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_launch      = 1'b1;
          w_launch_addr = w_target;
        end else if (stall_i == 4'b0000) begin
          w_launch      = 1'b1;
          w_launch_addr = r_pc + 32'd4;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= '0;
      r_cancel    <= 1'b0;
      r_hold_pc   <= '0;
      r_hold_inst <= '0;
      r_hold_ren  <= 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
      r_hold_exc  <= '0;
`endif
    end else if (w_launch) begin
      r_pc       <= w_launch_addr;
      r_req_addr <= w_launch_addr;
      r_cancel   <= 1'b0;
      r_state    <= S_REQ;
`ifdef FETCH_ADEL_CHECK_EN
      // A misaligned PC never reaches the bus; it is presented directly as an AdEL slot.
      if (w_launch_addr[1:0] != 2'b00) begin
        r_state     <= S_HOLD;
        r_hold_pc   <= w_launch_addr;
        r_hold_inst <= '0;
        r_hold_ren  <= 1'b0;
        r_hold_exc  <= ADEL_MASK;
      end
`endif
    end else begin
      unique case (r_state)
        S_REQ: begin
          // The address is already on the bus, so its response must be dropped later.
          if (w_redirect) begin
            r_pc     <= w_target;
            r_cancel <= 1'b1;
          end
          if (inst_addr_ok_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (inst_data_ok_i) begin
            r_state     <= S_HOLD;
            r_hold_pc   <= r_req_addr;
            r_hold_inst <= inst_rdata_i;
            r_hold_ren  <= 1'b1;
`ifdef FETCH_ADEL_CHECK_EN
            r_hold_exc  <= '0;
`endif
          end else if (w_redirect) begin
            r_pc     <= w_target;
            r_cancel <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign inst_req_o        = (r_state == S_REQ);
  assign if_inst_valid_o   = (r_state == S_HOLD);
  assign fetch_stall_req_o = (r_state != S_HOLD);
  assign if_inst_ren_o     = if_inst_valid_o & r_hold_ren;
  assign if_pc_o           = r_hold_pc;
  assign if_inst_o         = r_hold_inst;

`ifdef FETCH_ADEL_CHECK_EN
  assign inst_addr_o         = r_req_addr;
  assign if_exception_type_o = if_inst_valid_o ? r_hold_exc : '0;
`else
  assign inst_addr_o         = {r_req_addr[31:2], 2'b00};
  assign if_exception_type_o = '0;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: the bench plays the instruction bus, and a scoreboard queue
// holds each instruction it expects IF to see, in order.
module tb_fetch_seq_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [3:0]  stall_i;
  logic        branch_enable_i;
  logic [31:0] branch_target_i;
  logic        exception_i;
  logic [31:0] exception_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_inst_ren_o;
  logic        if_inst_valid_o;
  logic [31:0] if_exception_type_o;
  logic        fetch_stall_req_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clock_i = ~clock_i;

  fetch_seq_ctrl dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .stall_i             (stall_i),
    .branch_enable_i     (branch_enable_i),
    .branch_target_i     (branch_target_i),
    .exception_i         (exception_i),
    .exception_pc_i      (exception_pc_i),
    .inst_req_o          (inst_req_o),
    .inst_addr_o         (inst_addr_o),
    .inst_addr_ok_i      (inst_addr_ok_i),
    .inst_data_ok_i      (inst_data_ok_i),
    .inst_rdata_i        (inst_rdata_i),
    .if_pc_o             (if_pc_o),
    .if_inst_o           (if_inst_o),
    .if_inst_ren_o       (if_inst_ren_o),
    .if_inst_valid_o     (if_inst_valid_o),
    .if_exception_type_o (if_exception_type_o),
    .fetch_stall_req_o   (fetch_stall_req_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req"}, 32'(inst_req_o), 32'd1);
    chk({tag, "_addr"}, inst_addr_o, addr);
    chk({tag, "_valid"}, 32'(if_inst_valid_o), 32'd0);
  endtask

  task automatic check_presented(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q[0];
      chk({tag, "_pc"}, if_pc_o, e.pc);
      chk({tag, "_inst"}, if_inst_o, e.inst);
    end
    chk({tag, "_valid"}, 32'(if_inst_valid_o), 32'd1);
    chk({tag, "_ren"}, 32'(if_inst_ren_o), 32'd1);
    chk({tag, "_stallreq"}, 32'(fetch_stall_req_o), 32'd0);
    chk({tag, "_exc"}, if_exception_type_o, 32'd0);
  endtask

  // Instruction is taken by IF on the next edge; stall_i must already be zero.
  task automatic present_and_consume(input string tag);
    check_presented(tag);
    tick();
    if (sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  // Accept the pending request next cycle, then return data after wait_cycles idle cycles.
  task automatic complete_txn(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input int wait_cycles);
    exp_t e;
    check_req(tag, addr);
    inst_addr_ok_i = 1'b1;
    tick();
    inst_addr_ok_i = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      chk({tag, "_wait_noreq"}, 32'(inst_req_o), 32'd0);
      tick();
    end
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = data;
    e.pc   = addr;
    e.inst = data;
    sb_q.push_back(e);
    tick();
    inst_data_ok_i = 1'b0;
    inst_rdata_i   = '0;
  endtask

  task automatic drop_pending_response(input logic [31:0] junk);
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = junk;
    tick();
    inst_data_ok_i = 1'b0;
    inst_rdata_i   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i         = 1'b1;
    stall_i         = '0;
    branch_enable_i = 1'b0;
    branch_target_i = '0;
    exception_i     = 1'b0;
    exception_pc_i  = '0;
    inst_addr_ok_i  = 1'b0;
    inst_data_ok_i  = 1'b0;
    inst_rdata_i    = '0;
    #2 reset_i = 1'b0;
    tick();
    tick();

    chk("rst_req", 32'(inst_req_o), 32'd0);
    chk("rst_addr", inst_addr_o, 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_ren", 32'(if_inst_ren_o), 32'd0);
    chk("rst_valid", 32'(if_inst_valid_o), 32'd0);
    chk("rst_exc", if_exception_type_o, 32'd0);
    chk("rst_stallreq", 32'(fetch_stall_req_o), 32'd1);

    reset_i = 1'b1;
    tick();

    // First fetch: addr_ok next cycle, data two cycles after that.
    complete_txn("t1", 32'hBFC00000, 32'h24010001, 1);
    present_and_consume("t1");
    check_req("t1_next", 32'hBFC00004);

    // Stalled instruction held for five cycles with no new request.
    stall_i = 4'b0010;
    complete_txn("t2", 32'hBFC00004, 32'h8C220000, 0);
    for (int i = 0; i < 5; i++) begin
      check_presented("t2_hold");
      chk("t2_noreq", 32'(inst_req_o), 32'd0);
      tick();
    end
    stall_i = 4'b0000;
    present_and_consume("t2");
    check_req("t2_next", 32'hBFC00008);

    // Branch while waiting for data: old response dropped.
    inst_addr_ok_i = 1'b1;
    tick();
    inst_addr_ok_i  = 1'b0;
    branch_enable_i = 1'b1;
    branch_target_i = 32'hBFC00100;
    tick();
    branch_enable_i = 1'b0;
    branch_target_i = '0;
    chk("t3_wait_valid", 32'(if_inst_valid_o), 32'd0);
    tick();
    drop_pending_response(32'hDEADBEEF);
    check_req("t3_tgt", 32'hBFC00100);
    complete_txn("t3b", 32'hBFC00100, 32'h3C1D8000, 0);
    present_and_consume("t3b");
    check_req("t3_next", 32'hBFC00104);

    // Exception and branch together with data_ok: exception wins, data dropped.
    inst_addr_ok_i = 1'b1;
    tick();
    inst_addr_ok_i  = 1'b0;
    exception_i     = 1'b1;
    exception_pc_i  = 32'hBFC00380;
    branch_enable_i = 1'b1;
    branch_target_i = 32'hBFC00200;
    drop_pending_response(32'hCAFEF00D);
    exception_i     = 1'b0;
    exception_pc_i  = '0;
    branch_enable_i = 1'b0;
    branch_target_i = '0;
    check_req("t4_exc", 32'hBFC00380);
    complete_txn("t4b", 32'hBFC00380, 32'h401A6800, 0);
    present_and_consume("t4b");
    check_req("t4_next", 32'hBFC00384);

    // Slow addr_ok with a branch while the address is pending.
    for (int i = 0; i < 4; i++) begin
      check_req("t5_stable", 32'hBFC00384);
      branch_enable_i = (i == 1);
      branch_target_i = 32'hBFC00500;
      tick();
    end
    branch_enable_i = 1'b0;
    branch_target_i = '0;
    check_req("t5_accept", 32'hBFC00384);
    inst_addr_ok_i = 1'b1;
    tick();
    inst_addr_ok_i = 1'b0;
    drop_pending_response(32'h0BADF00D);
    check_req("t5_tgt", 32'hBFC00500);
    complete_txn("t5b", 32'hBFC00500, 32'h27BDFFE0, 0);
    present_and_consume("t5b");
    check_req("t5_next", 32'hBFC00504);

    // Two redirects during one transaction: latest target wins, one response dropped.
    inst_addr_ok_i = 1'b1;
    tick();
    inst_addr_ok_i  = 1'b0;
    branch_enable_i = 1'b1;
    branch_target_i = 32'hBFC00600;
    tick();
    branch_target_i = 32'hBFC00700;
    tick();
    branch_enable_i = 1'b0;
    branch_target_i = '0;
    drop_pending_response(32'h11111111);
    check_req("t6_tgt", 32'hBFC00700);
    complete_txn("t6b", 32'hBFC00700, 32'hAFBF001C, 0);
    present_and_consume("t6b");
    check_req("t6_next", 32'hBFC00704);

    // Exception while a stalled instruction is held: it is discarded.
    stall_i = 4'b1000;
    complete_txn("t7", 32'hBFC00704, 32'h03E00008, 0);
    check_presented("t7_held");
    exception_i    = 1'b1;
    exception_pc_i = 32'hBFC00380;
    tick();
    exception_i    = 1'b0;
    exception_pc_i = '0;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    stall_i = 4'b0000;
    check_req("t7_exc", 32'hBFC00380);

    // Branch to a misaligned target.
    inst_addr_ok_i = 1'b1;
    tick();
    inst_addr_ok_i  = 1'b0;
    branch_enable_i = 1'b1;
    branch_target_i = 32'hBFC00102;
    tick();
    branch_enable_i = 1'b0;
    branch_target_i = '0;
    drop_pending_response(32'h22222222);
`ifdef FETCH_ADEL_CHECK_EN
    chk("t8_noreq", 32'(inst_req_o), 32'd0);
    chk("t8_valid", 32'(if_inst_valid_o), 32'd1);
    chk("t8_pc", if_pc_o, 32'hBFC00102);
    chk("t8_exc", if_exception_type_o, 32'h00000001);
    chk("t8_ren", 32'(if_inst_ren_o), 32'd0);
    chk("t8_inst", if_inst_o, 32'd0);
    branch_enable_i = 1'b1;
    branch_target_i = 32'hFFFFFFFC;
    tick();
    branch_enable_i = 1'b0;
    branch_target_i = '0;
`else
    check_req("t8_forced", 32'hBFC00100);
    chk("t8_exc", if_exception_type_o, 32'd0);
    branch_enable_i = 1'b1;
    branch_target_i = 32'hFFFFFFFC;
    inst_addr_ok_i  = 1'b1;
    tick();
    branch_enable_i = 1'b0;
    branch_target_i = '0;
    inst_addr_ok_i  = 1'b0;
    drop_pending_response(32'h33333333);
`endif

    // PC increment wraps at the top of the address space.
    complete_txn("t9", 32'hFFFFFFFC, 32'h1000FFFF, 0);
    present_and_consume("t9");
    check_req("t9_wrap", 32'h00000000);

    // Asynchronous reset in the middle of a transaction.
    inst_addr_ok_i = 1'b1;
    tick();
    inst_addr_ok_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    chk("t10_rst_req", 32'(inst_req_o), 32'd0);
    chk("t10_rst_addr", inst_addr_o, 32'd0);
    chk("t10_rst_valid", 32'(if_inst_valid_o), 32'd0);
    chk("t10_rst_stallreq", 32'(fetch_stall_req_o), 32'd1);
    tick();
    reset_i = 1'b1;
    tick();
    complete_txn("t10", 32'hBFC00000, 32'h24010001, 1);
    present_and_consume("t10");
    check_req("t10_next", 32'hBFC00004);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
